// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - data-memory bus between the memory stage and the memory
//
// Single-outstanding request/ready bus with a separate rvalid response.
//   dmem_req    stage -> mem  request valid
//   dmem_we     stage -> mem  1 = store, 0 = load
//   dmem_addr   stage -> mem  word-aligned byte address
//   dmem_be     stage -> mem  byte enables
//   dmem_wdata  stage -> mem  store data, replicated across lanes
//   dmem_ready  mem -> stage  request accepted this cycle
//   dmem_rvalid mem -> stage  load data valid
//   dmem_rdata  mem -> stage  load data word
interface mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_ready, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_ready, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline memory-access stage (EX/MEM -> MEM/WB)
//
// Decodes loads/stores from the EX/MEM instruction word, performs one data
// access at a time on the dmem bus, formats load data and registers MEM/WB.
// Non-memory instructions pass through in one cycle; memory operations hold
// the upstream pipeline through mem_stall until they complete.
//
// Optional feature macro: MEM_MISALIGN_TRAP_EN. When defined, misaligned
// halfword/word accesses skip the bus and complete at once with
// mem_misalign = 1. When undefined, the address is force-aligned instead.
//
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   ex_mem_valid/ir/alu/b      EX/MEM bundle (alu = effective address)
//   dmem                       data-memory bus (master side)
//   mem_stall                  hold EX/MEM (combinational)
//   mem_wb_valid/ir/alu/lmd    registered MEM/WB bundle
//   mem_misalign               misaligned-access flag
module mem_stage (
  input  logic               clk,
  input  logic               reset,
  input  logic               ex_mem_valid,
  input  logic [31:0]        ex_mem_ir,
  input  logic [31:0]        ex_mem_alu,
  input  logic [31:0]        ex_mem_b,
  mem_stage_if.master        dmem,
  output logic               mem_stall,
  output logic               mem_wb_valid,
  output logic [31:0]        mem_wb_ir,
  output logic [31:0]        mem_wb_alu,
  output logic [31:0]        mem_wb_lmd,
  output logic               mem_misalign
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  f3_q, f3_d;
  logic        wb_valid_q, wb_valid_d;
  logic [31:0] wb_ir_q, wb_ir_d;
  logic [31:0] wb_alu_q, wb_alu_d;
  logic [31:0] wb_lmd_q, wb_lmd_d;
  logic        misalign_q, misalign_d;

  // Decode of the incoming bundle
  logic [2:0]  funct3;
  logic        is_load, is_store, is_mem, is_b, is_h, trap;
  logic [1:0]  raw_off, off_calc;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;

  assign funct3   = ex_mem_ir[14:12];
  assign is_load  = (ex_mem_ir[6:0] == 7'b0000011);
  assign is_store = (ex_mem_ir[6:0] == 7'b0100011);
  assign is_mem   = ex_mem_valid & (is_load | is_store);
  assign is_b     = (funct3 == 3'b000) | (funct3 == 3'b100);
  assign is_h     = (funct3 == 3'b001) | (funct3 == 3'b101);
  assign raw_off  = ex_mem_alu[1:0];

`ifdef MEM_MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = (is_h & raw_off[0]) | (~is_b & ~is_h & (raw_off != 2'b00));
  assign trap       = is_mem & misaligned;
`else
  assign trap       = 1'b0;
`endif

  // Offset cleared to natural alignment; only matters when not trapping.
  assign off_calc   = is_b ? raw_off : (is_h ? {raw_off[1], 1'b0} : 2'b00);
  assign be_calc    = is_b ? (4'b0001 << off_calc)
                    : (is_h ? (4'b0011 << {off_calc[1], 1'b0}) : 4'b1111);
  assign wdata_calc = is_b ? {4{ex_mem_b[7:0]}}
                    : (is_h ? {2{ex_mem_b[15:0]}} : ex_mem_b);

  // Load formatting from the captured size/offset
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] lmd_fmt;

  always_comb begin
    lane_b = dmem.dmem_rdata[7:0];
    case (off_q)
      2'd1:    lane_b = dmem.dmem_rdata[15:8];
      2'd2:    lane_b = dmem.dmem_rdata[23:16];
      2'd3:    lane_b = dmem.dmem_rdata[31:24];
      default: lane_b = dmem.dmem_rdata[7:0];
    endcase
    lane_h = off_q[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
    case (f3_q)
      3'b000:  lmd_fmt = {{24{lane_b[7]}}, lane_b};
      3'b100:  lmd_fmt = {24'd0, lane_b};
      3'b001:  lmd_fmt = {{16{lane_h[15]}}, lane_h};
      3'b101:  lmd_fmt = {16'd0, lane_h};
      default: lmd_fmt = dmem.dmem_rdata;
    endcase
  end

  // Next-state and MEM/WB update
  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    off_d      = off_q;
    f3_d       = f3_q;
    wb_valid_d = 1'b0;
    wb_ir_d    = wb_ir_q;
    wb_alu_d   = wb_alu_q;
    wb_lmd_d   = wb_lmd_q;
    misalign_d = 1'b0;
    mem_stall  = 1'b0;
    case (state_q)
      IDLE: begin
        if (is_mem && !trap) begin
          mem_stall = 1'b1;
          we_d      = is_store;
          addr_d    = {ex_mem_alu[31:2], 2'b00};
          be_d      = be_calc;
          wdata_d   = wdata_calc;
          off_d     = off_calc;
          f3_d      = funct3;
          state_d   = REQ;
        end else begin
          // Pass-through; a trapped access also completes here with lmd = 0.
          wb_valid_d = ex_mem_valid;
          wb_ir_d    = ex_mem_ir;
          wb_alu_d   = ex_mem_alu;
          wb_lmd_d   = 32'd0;
          misalign_d = trap;
        end
      end
      REQ: begin
        mem_stall = !(dmem.dmem_ready && we_q);
        if (dmem.dmem_ready) begin
          if (we_q) begin
            wb_valid_d = 1'b1;
            wb_ir_d    = ex_mem_ir;
            wb_alu_d   = ex_mem_alu;
            wb_lmd_d   = 32'd0;
            state_d    = IDLE;
          end else begin
            state_d    = RESP;
          end
        end
      end
      RESP: begin
        mem_stall = !dmem.dmem_rvalid;
        if (dmem.dmem_rvalid) begin
          wb_valid_d = 1'b1;
          wb_ir_d    = ex_mem_ir;
          wb_alu_d   = ex_mem_alu;
          wb_lmd_d   = lmd_fmt;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      addr_q     <= 32'd0;
      be_q       <= 4'd0;
      wdata_q    <= 32'd0;
      off_q      <= 2'd0;
      f3_q       <= 3'd0;
      wb_valid_q <= 1'b0;
      wb_ir_q    <= 32'd0;
      wb_alu_q   <= 32'd0;
      wb_lmd_q   <= 32'd0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      off_q      <= off_d;
      f3_q       <= f3_d;
      wb_valid_q <= wb_valid_d;
      wb_ir_q    <= wb_ir_d;
      wb_alu_q   <= wb_alu_d;
      wb_lmd_q   <= wb_lmd_d;
      misalign_q <= misalign_d;
    end
  end

  // Request is a decode of the state register, so reset drops it at once.
  assign dmem.dmem_req   = (state_q == REQ);
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_be    = be_q;
  assign dmem.dmem_wdata = wdata_q;

  assign mem_wb_valid = wb_valid_q;
  assign mem_wb_ir    = wb_ir_q;
  assign mem_wb_alu   = wb_alu_q;
  assign mem_wb_lmd   = wb_lmd_q;
  assign mem_misalign = misalign_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage
module tb_mem_stage;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ALU   = 7'b0110011;
`ifdef MEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        ex_mem_valid;
  logic [31:0] ex_mem_ir, ex_mem_alu, ex_mem_b;
  logic        mem_stall, mem_wb_valid, mem_misalign;
  logic [31:0] mem_wb_ir, mem_wb_alu, mem_wb_lmd;

  int n_cmp = 0;
  int n_bad = 0;

  mem_stage_if bus ();

  mem_stage dut (
    .clk          (clk),
    .reset        (reset),
    .ex_mem_valid (ex_mem_valid),
    .ex_mem_ir    (ex_mem_ir),
    .ex_mem_alu   (ex_mem_alu),
    .ex_mem_b     (ex_mem_b),
    .dmem         (bus),
    .mem_stall    (mem_stall),
    .mem_wb_valid (mem_wb_valid),
    .mem_wb_ir    (mem_wb_ir),
    .mem_wb_alu   (mem_wb_alu),
    .mem_wb_lmd   (mem_wb_lmd),
    .mem_misalign (mem_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents one instruction at posedge+1 and acts as the memory. Expected
  // values come from the access rules: size in bytes, natural alignment,
  // lane replication by multiplication, and the documented latency formula.
  task automatic do_op(input logic [6:0] opc, input logic [2:0] f3,
                       input logic [31:0] alu, input logic [31:0] b,
                       input logic [31:0] rdata, input int rdly, input int vdly,
                       output logic [31:0] lmd_obs);
    logic [31:0] r, ir, mask, v, e_addr, e_wd, e_lmd, rep;
    logic [3:0]  m4, e_be;
    int size, aoff, off, e_lat, waited, vcnt, naccept;
    bit is_ld, is_st, trap, accepted, fire, req_s, done;

    r = $urandom();
    ir = {r[31:15], f3, r[11:7], opc};
    is_ld = (opc == OP_LOAD);
    is_st = (opc == OP_STORE);
    size = (f3 == 3'd0 || f3 == 3'd4) ? 1 : ((f3 == 3'd1 || f3 == 3'd5) ? 2 : 4);
    aoff = int'(alu[1:0]);
    trap = TRAP && (is_ld || is_st) && ((aoff % size) != 0);
    off = (aoff / size) * size;
    e_addr = alu - 32'(aoff);
    m4 = (size == 1) ? 4'b0001 : ((size == 2) ? 4'b0011 : 4'b1111);
    e_be = m4 << off;
    mask = 32'hFFFF_FFFF >> (32 - 8 * size);
    rep = (size == 1) ? 32'h0101_0101 : ((size == 2) ? 32'h0001_0001 : 32'h1);
    e_wd = (b & mask) * rep;
    v = (rdata >> (8 * off)) & mask;
    if (size < 4 && !f3[2] && v[8 * size - 1]) v = v | ~mask;
    e_lmd = (is_ld && !trap) ? v : 32'd0;
    e_lat = (!(is_ld || is_st) || trap) ? 1 : (is_st ? 2 + rdly : 3 + rdly + vdly);

    ex_mem_valid = 1'b1;
    ex_mem_ir = ir;
    ex_mem_alu = alu;
    ex_mem_b = b;
    waited = 0; vcnt = 0; naccept = 0; accepted = 0; done = 0;
    lmd_obs = 32'd0;
    for (int c = 0; c < 40 && !done; c++) begin
      bus.dmem_ready  = bus.dmem_req && !accepted && (waited == rdly);
      bus.dmem_rvalid = is_ld && accepted && (vcnt == vdly);
      bus.dmem_rdata  = bus.dmem_rvalid ? rdata : $urandom();
      #4;
      chk("stall", 32'(mem_stall), 32'(c < e_lat - 1));
      req_s = bus.dmem_req;
      if (req_s) begin
        chk("addr", bus.dmem_addr, e_addr);
        chk("be", 32'(bus.dmem_be), 32'(e_be));
        chk("we", 32'(bus.dmem_we), 32'(is_st));
        if (is_st) chk("wdata", bus.dmem_wdata, e_wd);
      end
      fire = req_s && bus.dmem_ready;
      @(posedge clk); #1;
      if (accepted) vcnt++;
      if (fire) begin
        accepted = 1;
        naccept++;
      end else if (req_s) begin
        waited++;
      end
      if (mem_wb_valid) begin
        done = 1;
        chk("latency", 32'(c + 1), 32'(e_lat));
        chk("wb_ir", mem_wb_ir, ir);
        chk("wb_alu", mem_wb_alu, alu);
        chk("wb_lmd", mem_wb_lmd, e_lmd);
        chk("misalign", 32'(mem_misalign), 32'(trap));
        lmd_obs = mem_wb_lmd;
      end
    end
    if (!done) chk("timeout", 32'd0, 32'd1);
    chk("accepts", 32'(naccept), 32'((is_ld || is_st) && !trap));
    bus.dmem_ready = 1'b0;
    bus.dmem_rvalid = 1'b0;
  endtask

  initial begin
    logic [31:0] lmd;
    logic [2:0]  f3s [7];
    int          kind;
    logic [6:0]  opc;
    logic [31:0] a;

    f3s = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6};
    reset = 1'b0;
    ex_mem_valid = 1'b0;
    ex_mem_ir = 32'd0;
    ex_mem_alu = 32'd0;
    ex_mem_b = 32'd0;
    bus.dmem_ready = 1'b0;
    bus.dmem_rvalid = 1'b0;
    bus.dmem_rdata = 32'd0;
    #1;
    chk("rst_req", 32'(bus.dmem_req), 32'd0);
    chk("rst_we", 32'(bus.dmem_we), 32'd0);
    chk("rst_addr", bus.dmem_addr, 32'd0);
    chk("rst_be", 32'(bus.dmem_be), 32'd0);
    chk("rst_wdata", bus.dmem_wdata, 32'd0);
    chk("rst_stall", 32'(mem_stall), 32'd0);
    chk("rst_wb_valid", 32'(mem_wb_valid), 32'd0);
    chk("rst_wb_ir", mem_wb_ir, 32'd0);
    chk("rst_wb_alu", mem_wb_alu, 32'd0);
    chk("rst_wb_lmd", mem_wb_lmd, 32'd0);
    chk("rst_misalign", 32'(mem_misalign), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Directed cases
    do_op(OP_ALU, 3'd0, 32'h0000_1234, 32'h5, 32'h0, 0, 0, lmd);
    do_op(OP_STORE, 3'd0, 32'h0000_1003, 32'hAABB_CCDD, 32'h0, 2, 0, lmd);
    do_op(OP_LOAD, 3'd0, 32'h0000_1002, 32'h0, 32'h0080_FF00, 0, 0, lmd);
    chk("lb_const", lmd, 32'hFFFF_FF80);
    do_op(OP_LOAD, 3'd4, 32'h0000_1002, 32'h0, 32'h0080_FF00, 0, 0, lmd);
    chk("lbu_const", lmd, 32'h0000_0080);
    do_op(OP_LOAD, 3'd1, 32'h0000_2002, 32'h0, 32'h8001_0000, 0, 3, lmd);
    chk("lh_const", lmd, 32'hFFFF_8001);
    do_op(OP_LOAD, 3'd2, 32'h0000_3002, 32'h0, 32'h1357_9BDF, 1, 1, lmd);
    chk("lw_const", lmd, TRAP ? 32'd0 : 32'h1357_9BDF);

    // Reset while a load waits in RESP
    ex_mem_valid = 1'b1;
    ex_mem_ir = {17'd0, 3'd2, 5'd1, OP_LOAD};
    ex_mem_alu = 32'h0000_0040;
    @(posedge clk); #1;
    bus.dmem_ready = 1'b1;
    @(posedge clk); #1;
    bus.dmem_ready = 1'b0;
    chk("resp_req", 32'(bus.dmem_req), 32'd0);
    chk("resp_stall", 32'(mem_stall), 32'd1);
    ex_mem_valid = 1'b0;
    #3 reset = 1'b0;
    #1;
    chk("arst_req", 32'(bus.dmem_req), 32'd0);
    chk("arst_wb_valid", 32'(mem_wb_valid), 32'd0);
    chk("arst_stall", 32'(mem_stall), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.dmem_rvalid = 1'b1;
      bus.dmem_rdata = $urandom();
      @(posedge clk); #1;
      chk("stray_wb_valid", 32'(mem_wb_valid), 32'd0);
      chk("stray_req", 32'(bus.dmem_req), 32'd0);
    end
    bus.dmem_rvalid = 1'b0;

    // Randomized mix
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 2);
      opc = (kind == 0) ? OP_ALU : ((kind == 1) ? OP_LOAD : OP_STORE);
      a = $urandom();
      do_op(opc, f3s[$urandom_range(0, 6)], a, $urandom(), $urandom(),
            $urandom_range(0, 3), $urandom_range(0, 3), lmd);
    end

    ex_mem_valid = 1'b0;
    @(posedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
